// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: funct7/funct3 encodings, M-extension ops and FSM states.
package alu_seq_pkg;

    typedef enum logic [6:0] {
        Normal = 7'b0000000,
        Alt    = 7'b0100000,
        Muldiv = 7'b0000001
    } alu_funct7_e;

    typedef enum logic [2:0] {
        Add  = 3'd0,
        Sll  = 3'd1,
        Slt  = 3'd2,
        Sltu = 3'd3,
        Xor  = 3'd4,
        Srl  = 3'd5,
        Or   = 3'd6,
        And  = 3'd7
    } alu_funct3_e;

    typedef enum logic [2:0] {
        Mul    = 3'd0,
        Mulh   = 3'd1,
        Mulhsu = 3'd2,
        Mulhu  = 3'd3,
        Div    = 3'd4,
        Divu   = 3'd5,
        Rem    = 3'd6,
        Remu   = 3'd7
    } alu_md_funct3_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Issue-side request and writeback-side response of the sequential ALU, both valid/ready.
interface alu_seq_if
    import alu_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) ();

    logic            valid_i;
    logic            ready_o;
    logic [XLEN-1:0] operand_1_i;
    logic [XLEN-1:0] operand_2_i;
    alu_funct7_e     funct7_i;
    alu_funct3_e     funct3_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;

    modport slave (
        input  valid_i, operand_1_i, operand_2_i, funct7_i, funct3_i, ready_i,
        output ready_o, valid_o, result_o
    );

    modport master (
        output valid_i, operand_1_i, operand_2_i, funct7_i, funct3_i, ready_i,
        input  ready_o, valid_o, result_o
    );

endinterface

// File: rtl/alu_divider.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// The first bit is resolved in the start cycle so done_o rises Width-1 cycles after start_i.
module alu_divider #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [Width-1:0] dividend_i,
    input  logic [Width-1:0] divisor_i,
    output logic             done_o,
    output logic [Width-1:0] quotient_o,
    output logic [Width-1:0] remainder_o
);

    localparam int unsigned CntW = $clog2(Width) + 1;

    logic             busy_q, done_q;
    logic [CntW-1:0]  cnt_q;
    logic [Width-1:0] rem_q, quo_q, dsor_q;
    logic [Width-1:0] src_rem, src_quo, src_dsor, rem_next, quo_next;
    logic [Width:0]   shifted, trial;

    // Partial remainder stays below the divisor, so one extra bit holds the trial sign.
    always_comb begin
        src_rem  = start_i ? {Width{1'b0}} : rem_q;
        src_quo  = start_i ? dividend_i : quo_q;
        src_dsor = start_i ? divisor_i : dsor_q;
        shifted  = {src_rem, src_quo[Width-1]};
        trial    = shifted - {1'b0, src_dsor};
        rem_next = trial[Width] ? shifted[Width-1:0] : trial[Width-1:0];
        quo_next = {src_quo[Width-2:0], ~trial[Width]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dsor_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q  <= rem_next;
                quo_q  <= quo_next;
                dsor_q <= divisor_i;
                cnt_q  <= CntW'(1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= rem_next;
                quo_q <= quo_next;
                if (cnt_q == CntW'(Width - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign done_o      = done_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential RV32I/M execute ALU: base ops in one cycle, multiply/divide iterate one bit per cycle.
// Valid/ready on both sides; the result register holds until the consumer takes it.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    alu_seq_if.slave bus
);

    localparam int unsigned CntW = $clog2(XLEN) + 1;
    localparam int unsigned ShW  = $clog2(XLEN);
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    alu_state_e       state_q;
    logic             valid_q, neg_q;
    logic [XLEN-1:0]  result_q, mcand_q;
    logic [2*XLEN-1:0] prod_q;
    logic [CntW-1:0]  cnt_q;
    alu_md_funct3_e   op_q;

    logic             ready, accept, is_md, is_mul, special, res_neg, div_start, div_done;
    logic             a_signed, b_signed, a_neg, b_neg, div_zero, overflow;
    alu_md_funct3_e   md_op;
    logic [ShW-1:0]   shamt;
    logic [XLEN-1:0]  a, b, a_mag, b_mag, base_res, special_res;
    logic [XLEN-1:0]  div_quo, div_rem, quo_fix, rem_fix, div_res, mul_res;
    logic [XLEN:0]    sum;
    logic [2*XLEN-1:0] prod_next, prod_fix;

    assign a     = bus.operand_1_i;
    assign b     = bus.operand_2_i;
    assign shamt = b[ShW-1:0];

    always_comb begin
        base_res = '0;
        if (bus.funct7_i == Normal) begin
            unique case (bus.funct3_i)
                Add:     base_res = a + b;
                Sll:     base_res = a << shamt;
                Slt:     base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
                Sltu:    base_res = {{(XLEN-1){1'b0}}, a < b};
                Xor:     base_res = a ^ b;
                Srl:     base_res = a >> shamt;
                Or:      base_res = a | b;
                And:     base_res = a & b;
                default: base_res = '0;
            endcase
        end else if (bus.funct7_i == Alt) begin
            if (bus.funct3_i == Add) begin
                base_res = a - b;
            end else if (bus.funct3_i == Srl) begin
                base_res = $signed(a) >>> shamt;
            end
        end
    end

    // M-extension decode; divide special cases resolve without iterating.
    always_comb begin
        md_op    = alu_md_funct3_e'(bus.funct3_i);
        is_md    = (bus.funct7_i == Muldiv);
        is_mul   = ~md_op[2];
        a_signed = (md_op == Mulh) || (md_op == Mulhsu) || (md_op == Div) || (md_op == Rem);
        b_signed = (md_op == Mulh) || (md_op == Div) || (md_op == Rem);
        a_neg    = a_signed & a[XLEN-1];
        b_neg    = b_signed & b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        res_neg  = ((md_op == Rem) || (md_op == Remu)) ? a_neg : (a_neg ^ b_neg);
        div_zero = (b == '0);
        overflow = ((md_op == Div) || (md_op == Rem)) && (a == MinInt) && (b == '1);
        special  = ~is_mul & (div_zero | overflow);
        if (div_zero) begin
            special_res = ((md_op == Div) || (md_op == Divu)) ? '1 : a;
        end else begin
            special_res = (md_op == Div) ? MinInt : '0;
        end
    end

    assign ready     = (state_q == StIdle) | ((state_q == StDone) & bus.ready_i);
    assign accept    = bus.valid_i & ready;
    assign div_start = accept & is_md & ~is_mul & ~special;

    // Last shift-add step, sign fix and half select share one cycle.
    always_comb begin
        sum       = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? mcand_q : {XLEN{1'b0}})};
        prod_next = {sum, prod_q[XLEN-1:1]};
        prod_fix  = neg_q ? -prod_next : prod_next;
        mul_res   = (op_q == Mul) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        quo_fix   = neg_q ? -div_quo : div_quo;
        rem_fix   = neg_q ? -div_rem : div_rem;
        div_res   = ((op_q == Rem) || (op_q == Remu)) ? rem_fix : quo_fix;
    end

    alu_divider #(
        .Width(XLEN)
    ) u_divider (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (div_start),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .done_o     (div_done),
        .quotient_o (div_quo),
        .remainder_o(div_rem)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            valid_q  <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= Mul;
            neg_q    <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if ((state_q == StDone) && bus.ready_i) begin
                        state_q <= StIdle;
                        valid_q <= 1'b0;
                    end
                    if (accept) begin
                        op_q  <= md_op;
                        neg_q <= res_neg;
                        cnt_q <= '0;
                        if (!is_md || special) begin
                            state_q  <= StDone;
                            valid_q  <= 1'b1;
                            result_q <= is_md ? special_res : base_res;
                        end else if (is_mul) begin
                            state_q <= StMul;
                            prod_q  <= {{XLEN{1'b0}}, b_mag};
                            mcand_q <= a_mag;
                        end else begin
                            state_q <= StDiv;
                        end
                    end
                end
                StMul: begin
                    prod_q <= prod_next;
                    if (cnt_q == CntW'(XLEN - 1)) begin
                        result_q <= mul_res;
                        valid_q  <= 1'b1;
                        state_q  <= StDone;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDiv: begin
                    if (div_done) begin
                        result_q <= div_res;
                        valid_q  <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ready_o  = ready;
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at XLEN=32 and XLEN=64; expected results go through a scoreboard queue.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [63:0] sb[$];
    logic [63:0] want;

    alu_seq_if #(.XLEN(32)) b32 ();
    alu_seq_if #(.XLEN(64)) b64 ();

    alu_seq #(.XLEN(32)) dut32 (.clk_i(clk), .rst_ni(rst_n), .bus(b32));
    alu_seq #(.XLEN(64)) dut64 (.clk_i(clk), .rst_ni(rst_n), .bus(b64));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue32(input string tag, input alu_funct7_e f7, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        b32.funct7_i    = f7;
        b32.funct3_i    = alu_funct3_e'(f3);
        b32.operand_1_i = a;
        b32.operand_2_i = b;
        b32.ready_i     = 1'b1;
        b32.valid_i     = 1'b1;
        sb.push_back({32'h0, exp});
        @(posedge clk);
        #1;
        b32.valid_i     = 1'b0;
        b32.operand_1_i = ~a;
        b32.operand_2_i = ~b;
        lat = 1;
        while (!b32.valid_o && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        want = sb.pop_front();
        check({tag, "_res"}, {32'h0, b32.result_o}, want);
    endtask

    task automatic issue64(input string tag, input alu_funct7_e f7, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        b64.funct7_i    = f7;
        b64.funct3_i    = alu_funct3_e'(f3);
        b64.operand_1_i = a;
        b64.operand_2_i = b;
        b64.ready_i     = 1'b1;
        b64.valid_i     = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        b64.valid_i = 1'b0;
        lat = 1;
        while (!b64.valid_o && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        want = sb.pop_front();
        check({tag, "_res"}, b64.result_o, want);
    endtask

    task automatic drain32();
        @(negedge clk);
        b32.valid_i = 1'b0;
        b32.ready_i = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        b32.valid_i = 1'b0; b32.ready_i = 1'b0; b32.operand_1_i = '0; b32.operand_2_i = '0;
        b32.funct7_i = Normal; b32.funct3_i = Add;
        b64.valid_i = 1'b0; b64.ready_i = 1'b0; b64.operand_1_i = '0; b64.operand_2_i = '0;
        b64.funct7_i = Normal; b64.funct3_i = Add;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {63'h0, b32.valid_o}, 64'h0);
        check("rst_result", {32'h0, b32.result_o}, 64'h0);
        check("rst_ready", {63'h0, b32.ready_o}, 64'h1);
        check("rst_valid64", {63'h0, b64.valid_o}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        issue32("add", Normal, Add, 32'd5, 32'd7, 32'd12, 1);
        issue32("sub", Alt, Add, 32'd0, 32'd1, 32'hFFFF_FFFF, 1);
        issue32("sra", Alt, Srl, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1);
        issue32("slt", Normal, Slt, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        issue32("sltu", Normal, Sltu, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        issue32("alt_xor", Alt, Xor, 32'd5, 32'd3, 32'd0, 1);

        issue32("mulh", Muldiv, Mulh, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33);
        issue32("mulhu", Muldiv, Mulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        issue32("mul", Muldiv, Mul, 32'd7, 32'd6, 32'd42, 33);
        issue32("mulhsu", Muldiv, Mulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

        issue32("div", Muldiv, Div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        issue32("rem", Muldiv, Rem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        issue32("divu", Muldiv, Divu, 32'd100, 32'd7, 32'd14, 33);
        issue32("remu", Muldiv, Remu, 32'd100, 32'd7, 32'd2, 33);

        issue32("divu_z", Muldiv, Divu, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        issue32("rem_z", Muldiv, Rem, 32'd5, 32'd0, 32'd5, 1);
        issue32("div_ovf", Muldiv, Div, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue32("rem_ovf", Muldiv, Rem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Consumer stalls for four cycles, then takes the result while a new op is accepted.
        drain32();
        @(negedge clk);
        b32.funct7_i = Normal; b32.funct3_i = Add;
        b32.operand_1_i = 32'd3; b32.operand_2_i = 32'd4;
        b32.ready_i = 1'b0; b32.valid_i = 1'b1;
        sb.push_back(64'd7);
        @(posedge clk);
        #1;
        b32.valid_i = 1'b0;
        check("hold_valid", {63'h0, b32.valid_o}, 64'h1);
        want = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            check("hold_result", {32'h0, b32.result_o}, want);
            check("hold_ready", {63'h0, b32.ready_o}, 64'h0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        b32.funct3_i = Xor;
        b32.operand_1_i = 32'h0000_00F0; b32.operand_2_i = 32'h0000_00FF;
        b32.ready_i = 1'b1; b32.valid_i = 1'b1;
        sb.push_back(64'h0F);
        #1;
        check("same_cycle_ready", {63'h0, b32.ready_o}, 64'h1);
        @(posedge clk);
        #1;
        b32.valid_i = 1'b0;
        check("b2b_valid", {63'h0, b32.valid_o}, 64'h1);
        want = sb.pop_front();
        check("b2b_result", {32'h0, b32.result_o}, want);

        // Reset in the middle of a divide: no result may appear.
        drain32();
        @(negedge clk);
        b32.funct7_i = Muldiv; b32.funct3_i = alu_funct3_e'(Div);
        b32.operand_1_i = 32'd1000; b32.operand_2_i = 32'd3;
        b32.valid_i = 1'b1;
        @(posedge clk);
        #1;
        b32.funct7_i = Normal; b32.funct3_i = Add;
        repeat (5) @(posedge clk);
        #1;
        check("holdoff_ready", {63'h0, b32.ready_o}, 64'h0);
        check("holdoff_valid", {63'h0, b32.valid_o}, 64'h0);
        @(negedge clk);
        b32.valid_i = 1'b0;
        b32.ready_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_valid", {63'h0, b32.valid_o}, 64'h0);
        check("abort_idle", {63'h0, b32.ready_o}, 64'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_result", {63'h0, b32.valid_o}, 64'h0);

        issue64("mulhu64", Muldiv, Mulhu, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 65);
        issue64("sll64", Normal, Sll, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1);
        issue64("div64", Muldiv, Div, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
